// File: rtl/adder_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_seq_ctrl_if
// Brief    : Operand/result handshake bundle for the nibble-serial adder.
// Revision : 1.0 - initial release
// ============================================================================
interface adder_seq_ctrl_if #(
    parameter int NIBBLES = 4
) ();
    localparam int c_W = 4 * NIBBLES;

    logic           in_valid;
    logic           in_ready;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           c_in;
    logic           out_valid;
    logic           out_ready;
    logic [c_W:0]   sum;
    logic           busy;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, busy
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, busy
    );
endinterface
`default_nettype wire

// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adder_seq_ctrl
// Brief    : Wide adder built by running one 4-bit ripple adder nibble-serially.
// Revision : 1.0 - initial release
// ============================================================================
module Adder_RAC (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C_in,
    output logic [4:0] C_out
);
    logic [4:0] w_c;

    assign w_c[0] = C_in;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_fa
            assign C_out[i]  = A[i] ^ B[i] ^ w_c[i];
            assign w_c[i+1]  = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
        end
    endgenerate

    assign C_out[4] = w_c[4];
endmodule

module adder_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    adder_seq_ctrl_if.slave  bus
);
    localparam int                 c_W     = 4 * NIBBLES;
    localparam int                 c_IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_W-1:0]     r_a;
    logic [c_W-1:0]     r_b;
    logic               r_carry;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_W:0]       r_sum;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic [c_W-1:0]     w_a_shift;
    logic [c_W-1:0]     w_b_shift;
    logic [4:0]         w_c_out;

    // Current nibble is brought down to bit 0 so the adder always sees [3:0].
    assign w_a_shift = r_a >> {r_idx, 2'b00};
    assign w_b_shift = r_b >> {r_idx, 2'b00};

    Adder_RAC u_adder (
        .A     (w_a_shift[3:0]),
        .B     (w_b_shift[3:0]),
        .C_in  (r_carry),
        .C_out (w_c_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_carry    <= bus.c_in;
                        r_sum      <= '0;
                        r_idx      <= '0;
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (r_idx == c_IDX_W'(i)) begin
                            r_sum[4*i +: 4] <= w_c_out[3:0];
                        end
                    end
                    r_carry <= w_c_out[4];
                    // idx parks on the last nibble rather than wrapping.
                    if (r_idx == c_LAST) begin
                        r_sum[c_W]  <= w_c_out[4];
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + c_IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.busy      = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_seq_ctrl
// Brief    : Directed-vector and randomized bench for adder_seq_ctrl (N=1,4,8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    int          sel;
    logic        t_valid;
    logic        t_oready;
    logic        t_cin;
    logic [31:0] t_a;
    logic [31:0] t_b;
    int          n_checks;
    int          n_fails;

    logic        m_in_ready;
    logic        m_out_valid;
    logic        m_busy;
    logic [32:0] m_sum;

    always #5 clk = ~clk;

    adder_seq_ctrl_if #(.NIBBLES(1)) if1 ();
    adder_seq_ctrl_if #(.NIBBLES(4)) if4 ();
    adder_seq_ctrl_if #(.NIBBLES(8)) if8 ();

    adder_seq_ctrl #(.NIBBLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    adder_seq_ctrl #(.NIBBLES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    adder_seq_ctrl #(.NIBBLES(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    // Only the selected instance sees valid/ready; the others stay idle.
    assign if1.in_valid  = t_valid  && (sel == 1);
    assign if1.out_ready = t_oready && (sel == 1);
    assign if1.a         = t_a[3:0];
    assign if1.b         = t_b[3:0];
    assign if1.c_in      = t_cin;
    assign if4.in_valid  = t_valid  && (sel == 4);
    assign if4.out_ready = t_oready && (sel == 4);
    assign if4.a         = t_a[15:0];
    assign if4.b         = t_b[15:0];
    assign if4.c_in      = t_cin;
    assign if8.in_valid  = t_valid  && (sel == 8);
    assign if8.out_ready = t_oready && (sel == 8);
    assign if8.a         = t_a;
    assign if8.b         = t_b;
    assign if8.c_in      = t_cin;

    always_comb begin
        m_in_ready  = if4.in_ready;
        m_out_valid = if4.out_valid;
        m_busy      = if4.busy;
        m_sum       = {16'd0, if4.sum};
        if (sel == 1) begin
            m_in_ready  = if1.in_ready;
            m_out_valid = if1.out_valid;
            m_busy      = if1.busy;
            m_sum       = {28'd0, if1.sum};
        end else if (sel == 8) begin
            m_in_ready  = if8.in_ready;
            m_out_valid = if8.out_valid;
            m_busy      = if8.busy;
            m_sum       = if8.sum;
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [32:0] exp;
    } vec_t;

    vec_t vecs4[8];
    vec_t vecs1[3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wmask(input int n);
        return (n >= 8) ? 32'hFFFF_FFFF : ((32'd1 << (4 * n)) - 32'd1);
    endfunction

    // One full transaction on the selected instance. Latency counts the
    // accept edge as edge 1, so the result shows up on edge NIBBLES+1.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic [32:0] exp, input int stall, input string tag);
        int edges;
        check({tag, "_idle_ready"}, m_in_ready, 1);
        t_a = a; t_b = b; t_cin = cin; t_valid = 1'b1;
        @(posedge clk); #1;
        t_valid = 1'b0;
        t_a = ~a; t_b = ~b; t_cin = ~cin;
        edges = 1;
        check({tag, "_busy"}, m_busy, 1);
        check({tag, "_run_ready"}, m_in_ready, 0);
        while (!m_out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_latency"}, edges, sel + 1);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        check({tag, "_sum"}, m_sum, exp);
        check({tag, "_valid_held"}, m_out_valid, 1);
        t_oready = 1'b1;
        @(posedge clk); #1;
        t_oready = 1'b0;
        check({tag, "_ready_after"}, m_in_ready, 1);
        check({tag, "_valid_after"}, m_out_valid, 0);
        check({tag, "_sum_kept"}, m_sum, exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic [32:0] rexp;
        int          ns[3];

        n_checks = 0; n_fails = 0;
        sel = 4; t_valid = 0; t_oready = 0; t_cin = 0; t_a = '0; t_b = '0;

        vecs4[0] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 33'h0_0001_0000};
        vecs4[1] = '{32'h0000_1234, 32'h0000_4321, 1'b1, 33'h0_0000_5556};
        vecs4[2] = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 33'h0_0001_FFFF};
        vecs4[3] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000};
        vecs4[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 33'h0_0000_0001};
        vecs4[5] = '{32'h0000_8000, 32'h0000_8000, 1'b0, 33'h0_0001_0000};
        vecs4[6] = '{32'h0000_ABCD, 32'h0000_1234, 1'b0, 33'h0_0000_BE01};
        vecs4[7] = '{32'h0000_0FFF, 32'h0000_0001, 1'b0, 33'h0_0000_1000};
        vecs1[0] = '{32'h0000_000F, 32'h0000_0001, 1'b1, 33'h0_0000_0011};
        vecs1[1] = '{32'h0000_0007, 32'h0000_0008, 1'b0, 33'h0_0000_000F};
        vecs1[2] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 33'h0_0000_0001};

        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", m_in_ready, 1);
        check("rst_out_valid", m_out_valid, 0);
        check("rst_busy", m_busy, 0);
        check("rst_sum", m_sum, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            do_op(vecs4[i].a, vecs4[i].b, vecs4[i].cin, vecs4[i].exp, i % 3,
                  $sformatf("vec4_%0d", i));

        // Backpressure: junk on the input side throughout RUN and 6 DONE cycles.
        check("bp_idle_ready", m_in_ready, 1);
        t_a = 32'h1111; t_b = 32'h2222; t_cin = 1'b0; t_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            t_valid = ~t_valid;
            t_a = $urandom; t_b = $urandom; t_cin = ~t_cin;
            @(posedge clk); #1;
            check($sformatf("bp_in_ready_%0d", i), m_in_ready, 0);
            if (i >= 3) begin
                check($sformatf("bp_sum_%0d", i), m_sum, 33'h0_0000_3333);
                check($sformatf("bp_valid_%0d", i), m_out_valid, 1);
            end
        end
        t_valid = 1'b0; t_oready = 1'b1;
        @(posedge clk); #1;
        t_oready = 1'b0;
        check("bp_ready_after", m_in_ready, 1);
        check("bp_valid_after", m_out_valid, 0);
        check("bp_sum_kept", m_sum, 33'h0_0000_3333);
        @(posedge clk); #1;
        check("bp_no_second_op", m_busy, 0);

        // Reset during the second RUN cycle discards the operation.
        t_a = 32'hFFFF; t_b = 32'hFFFF; t_cin = 1'b1; t_valid = 1'b1;
        @(posedge clk); #1;
        t_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_in_ready", m_in_ready, 1);
        check("mrst_out_valid", m_out_valid, 0);
        check("mrst_busy", m_busy, 0);
        check("mrst_sum", m_sum, 0);
        do_op(32'h0F0F, 32'h00F1, 1'b0, 33'h0_0000_1000, 0, "post_rst");

        sel = 1;
        for (int i = 0; i < 3; i++)
            do_op(vecs1[i].a, vecs1[i].b, vecs1[i].cin, vecs1[i].exp, i,
                  $sformatf("vec1_%0d", i));
        sel = 8;
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000, 1, "vec8_ripple");

        ns[0] = 1; ns[1] = 4; ns[2] = 8;
        for (int n = 0; n < 3; n++) begin
            sel = ns[n];
            for (int k = 0; k < 1000; k++) begin
                ra = $urandom & wmask(sel);
                rb = $urandom & wmask(sel);
                rc = 1'($urandom_range(0, 1));
                rexp = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
                do_op(ra, rb, rc, rexp, $urandom_range(0, 3), $sformatf("rnd%0d_%0d", sel, k));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/adder_seq_ctrl.md
# adder_seq_ctrl

Sequencer that computes wide additions by reusing one 4-bit ripple-carry adder (`Adder_RAC`) nibble-serially, one nibble per clock, least significant nibble first. The carry is held in a register between nibbles. Operands are accepted over a valid/ready input handshake and the result is returned over a valid/ready output handshake. The block sits between a requester that needs occasional wide sums and the single shared 4-bit adder, trading latency for area.

## Interface
Parameters:
- `NIBBLES`, default 4: operand width in nibbles. Operand width W = 4*NIBBLES. Legal range is NIBBLES ≥ 1.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  requester presents an operation.
- `in_ready`  out  1  block can accept an operation.
- `a`  in  W  operand A.
- `b`  in  W  operand B.
- `c_in`  in  1  carry-in into nibble 0.
- `out_valid`  out  1  `sum` holds a completed result.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  W+1  result; bit W is the final carry-out.
- `busy`  out  1  high in RUN and DONE.

## Operation
- One internal `Adder_RAC` instance.
  - Adder A/B inputs: nibble `idx` of the latched operands.
  - Adder C_in: the carry register.
  - Adder C_out[3:0]: written into `sum[4*idx+3:4*idx]`.
  - Adder C_out[4]: loaded into the carry register.
- State machine: IDLE, RUN, DONE.
  - IDLE: `in_ready`=1, `out_valid`=0. When `in_valid` is high, latch `a`, `b`, `c_in` into the operand and carry registers, clear `sum`, set `idx`=0, and go to RUN.
  - RUN: `in_ready`=0. Each cycle, write one sum nibble, update the carry, and increment `idx`. In the cycle where `idx`=NIBBLES-1, also write `sum[W]` from the adder carry-out and go to DONE.
  - DONE: `out_valid`=1. `sum` is held stable. When `out_ready` is high, go to IDLE.
- `in_valid` is ignored outside IDLE. Latched operands are unaffected by input changes after acceptance.
- `sum` is modified only during RUN. After DONE → IDLE it keeps its last value until the next accept clears it.
- `idx` width is clog2(NIBBLES), minimum 1 bit. It never exceeds NIBBLES-1.
- Arithmetic: `sum` = a + b + c_in, exact over W+1 bits with no truncation.
- Reset (any state, including mid-RUN):
  - State goes to IDLE; the in-flight operation is discarded with no output.
  - `sum`=0, carry register=0, `idx`=0.
  - `out_valid`=0, `busy`=0, `in_ready`=1 from the first cycle after reset.

## Timing
- Accept edge: the rising edge where IDLE, `in_valid`=1 and `in_ready`=1 all hold.
- RUN lasts exactly NIBBLES cycles. `out_valid` rises NIBBLES+1 edges after the accept edge.
- Result handshake edge: `out_valid`=1 and `out_ready`=1. `in_ready` is high on the following cycle.
- Minimum accept-to-accept spacing is NIBBLES+2 cycles, when `out_ready` is held high.
- Back-to-back handshakes are not overlapped. There is no combinational path from `out_ready` or `in_valid` to `in_ready`.
- All outputs are registered or decoded from registered state only.

## Test plan
- Full carry ripple (NIBBLES=4): a=0xFFFF, b=0x0001, c_in=0 → `sum`=0x10000, `out_valid` high 5 edges after accept.
- Carry-in and no overflow (NIBBLES=4): a=0x1234, b=0x4321, c_in=1 → `sum`=0x05556.
- Maximum value (NIBBLES=4): a=0xFFFF, b=0xFFFF, c_in=1 → `sum`=0x1FFFF.
- Backpressure and ignored input (NIBBLES=4): hold `out_ready`=0 for 6 cycles in DONE, and toggle `in_valid` with new operands throughout RUN/DONE. Required: `sum` stable, `in_ready`=0 throughout, no second operation started; after `out_ready` pulses, `in_ready`=1 on the next cycle.
- Reset mid-RUN: assert `rst` on the 2nd RUN cycle. Next cycle: IDLE, `sum`=0, `out_valid`=0, `in_ready`=1. Then a=0x0F0F, b=0x00F1, c_in=0 → `sum`=0x01000.
- NIBBLES=1: a=0xF, b=0x1, c_in=1 → `sum`=0x11, `out_valid` high 2 edges after accept.
- Random regression (NIBBLES=1, 4, 8): 1000 operations with random `out_ready` stalls, each result compared to a+b+c_in.
